wave_sequencer: RTL and testbench

Downstream consumer of the divided slow clock in the elementary waveform generator. Treats the divider output as a step strobe, not as a clock. Synchronises and edge-detects the strobe in the board-clock domain and advances a phase accumulator on each rising edge. Emits one 8-bit sample per step, selectable between square, sawtooth, triangle and optional sine, for the DAC/LED output stage.

---
 rtl/wave_pkg.sv | 28 ++
 rtl/sine_quarter_lut.sv | 22 ++
 rtl/wave_sequencer.sv | 102 ++++++++++
 tb/tb_wave_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// Shared encodings and shape helpers for the waveform sequencer.
package wave_pkg;

    localparam int unsigned SAMPLE_W       = 8;
    localparam int unsigned SINE_LUT_DEPTH = 64;
    localparam logic [SAMPLE_W-1:0] MID_SCALE = 8'h80;

    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'd0,
        WAVE_SAW    = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SINE   = 2'd3
    } wave_e;

    // Square/sawtooth/triangle from the top 8 phase bits; sine is built in the top level.
    function automatic logic [SAMPLE_W-1:0] shape_sample(wave_e sel, logic [SAMPLE_W-1:0] p);
        logic [SAMPLE_W-1:0] res;
        res = MID_SCALE;
        unique case (sel)
            WAVE_SQUARE: res = p[7] ? 8'h00 : 8'hFF;
            WAVE_SAW:    res = p;
            WAVE_TRI:    res = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
            WAVE_SINE:   res = MID_SCALE;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/sine_quarter_lut.sv
// Quarter-wave sine magnitude table: round(127*sin(pi*(2i+1)/256)) for i = 0..63.
module sine_quarter_lut
    import wave_pkg::*;
(
    input  logic [5:0] index_i,
    output logic [6:0] mag_o
);

    localparam logic [6:0] QuarterSine [SINE_LUT_DEPTH] = '{
        7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
        7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
        7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
        7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
        7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
        7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
        7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
    };

    assign mag_o = QuarterSine[index_i];

endmodule

// File: rtl/wave_sequencer.sv
// Step-strobe driven phase accumulator with registered waveform output.
// Optional sine generation is enabled by defining WAVE_SINE_EN.
module wave_sequencer
    import wave_pkg::*;
#(
    parameter int unsigned PHASE_W = 8
) (
    input  logic               clock_in,
    input  logic               reset_n,
    input  logic               step_in,
    input  logic [PHASE_W-1:0] phase_inc,
    input  logic [1:0]         wave_sel,
    input  logic               freeze,
    output logic [7:0]         sample,
    output logic               sample_valid,
    output logic               wrap,
    output logic [1:0]         wave_active
);

    logic [2:0]          sync_q;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    wave_e               wave_q, wave_d;
    logic                upd_q, upd_d;
    logic                carry_q, carry_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                valid_q, wrap_q;

    logic                step_edge, advance;
    logic [PHASE_W:0]    phase_sum;
    logic [SAMPLE_W-1:0] p, sine_val;

    assign p = phase_q[PHASE_W-1 -: SAMPLE_W];

`ifdef WAVE_SINE_EN
    logic [5:0] lut_idx;
    logic [6:0] lut_mag;

    // Mirror the index in the second and fourth quarters, flip sign in the back half.
    assign lut_idx  = p[6] ? ~p[5:0] : p[5:0];
    assign sine_val = p[7] ? (8'd127 - {1'b0, lut_mag}) : (8'd128 + {1'b0, lut_mag});

    sine_quarter_lut u_sine_lut (
        .index_i (lut_idx),
        .mag_o   (lut_mag)
    );
`else
    assign sine_val = MID_SCALE;
`endif

    always_comb begin
        step_edge = sync_q[1] & ~sync_q[2];
        advance   = step_edge & ~freeze;
        phase_sum = {1'b0, phase_q} + {1'b0, phase_inc};

        phase_d  = phase_q;
        wave_d   = wave_q;
        upd_d    = advance;
        carry_d  = 1'b0;
        sample_d = sample_q;

        if (advance) begin
            phase_d = phase_sum[PHASE_W-1:0];
            carry_d = phase_sum[PHASE_W];
            // New waveform only takes effect at a period boundary.
            if (phase_sum[PHASE_W]) begin
                wave_d = wave_e'(wave_sel);
            end
        end

        if (upd_q) begin
            sample_d = (wave_q == WAVE_SINE) ? sine_val : shape_sample(wave_q, p);
        end
    end

    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            sync_q   <= 3'b111;
            phase_q  <= '0;
            wave_q   <= WAVE_SQUARE;
            upd_q    <= 1'b0;
            carry_q  <= 1'b0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[1:0], step_in};
            phase_q  <= phase_d;
            wave_q   <= wave_d;
            upd_q    <= upd_d;
            carry_q  <= carry_d;
            sample_q <= sample_d;
            valid_q  <= upd_q;
            wrap_q   <= upd_q & carry_q;
        end
    end

    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign wrap         = wrap_q;
    assign wave_active  = wave_q;

endmodule

// File: tb/tb_wave_sequencer.sv
// Self-checking bench for wave_sequencer: vector table plus scoreboard of expected samples.
module tb_wave_sequencer;

    logic       clock_in = 1'b0;
    logic       reset_n;
    logic       step_in;
    logic [7:0] phase_inc;
    logic [1:0] wave_sel;
    logic       freeze;
    logic [7:0] sample;
    logic       sample_valid;
    logic       wrap;
    logic [1:0] wave_active;

    always #5 clock_in = ~clock_in;

    wave_sequencer #(.PHASE_W(8)) dut (
        .clock_in     (clock_in),
        .reset_n      (reset_n),
        .step_in      (step_in),
        .phase_inc    (phase_inc),
        .wave_sel     (wave_sel),
        .freeze       (freeze),
        .sample       (sample),
        .sample_valid (sample_valid),
        .wrap         (wrap),
        .wave_active  (wave_active)
    );

    typedef struct {
        logic       rst;
        logic [1:0] sel;
        logic [7:0] inc;
        logic       frz;
        logic [7:0] exp_sample;
        logic       exp_wrap;
        logic [1:0] exp_act;
    } vec_t;

    typedef struct {
        logic [7:0] sample;
        logic       wrap;
        logic [1:0] act;
    } exp_t;

    localparam int NumVec = 26;

    vec_t vecs [NumVec];
    exp_t sb [$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   n_valid = 0;

    function automatic vec_t mk(logic rst, logic [1:0] sel, logic [7:0] inc, logic frz,
                                logic [7:0] es, logic ew, logic [1:0] ea);
        vec_t v;
        v.rst = rst; v.sel = sel; v.inc = inc; v.frz = frz;
        v.exp_sample = es; v.exp_wrap = ew; v.exp_act = ea;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every valid pulse must match the oldest outstanding expectation.
    always @(negedge clock_in) begin
        exp_t e;
        if (wrap && !sample_valid) begin
            n_vec++;
            n_miss++;
            $display("FAIL wrap_without_valid: wrap=%b sample_valid=%b", wrap, sample_valid);
        end
        if (sample_valid) begin
            n_valid++;
            n_vec++;
            if (sb.size() == 0) begin
                n_miss++;
                $display("FAIL spurious_valid: got sample %h with no step pending", sample);
            end else begin
                e = sb.pop_front();
                if (sample !== e.sample || wrap !== e.wrap || wave_active !== e.act) begin
                    n_miss++;
                    $display("FAIL sample: got %h/wrap %b/active %0d expected %h/wrap %b/active %0d",
                             sample, wrap, wave_active, e.sample, e.wrap, e.act);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clock_in);
        reset_n = 1'b0;
        step_in = 1'b0;
        repeat (2) @(negedge clock_in);
        reset_n = 1'b1;
    endtask

    task automatic pulse_step();
        step_in = 1'b1;
        repeat (3) @(negedge clock_in);
        step_in = 1'b0;
        for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clock_in);
        if (sb.size() != 0) begin
            check("valid_timeout", 8'(sb.size()), 8'd0);
            sb.delete();
        end
        repeat (2) @(negedge clock_in);
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        int   base;
        if (v.rst) do_reset();
        @(negedge clock_in);
        wave_sel  = v.sel;
        phase_inc = v.inc;
        freeze    = v.frz;
        base      = n_valid;
        if (!v.frz) begin
            e.sample = v.exp_sample; e.wrap = v.exp_wrap; e.act = v.exp_act;
            sb.push_back(e);
        end
        pulse_step();
        if (v.frz) begin
            repeat (4) @(negedge clock_in);
            check($sformatf("freeze_no_valid[%0d]", idx), 8'(n_valid - base), 8'd0);
            freeze = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   base;
        reset_n   = 1'b0;
        step_in   = 1'b0;
        phase_inc = '0;
        wave_sel  = '0;
        freeze    = 1'b0;

        vecs[0]  = mk(1, 2'd1, 8'd128, 0, 8'h00, 0, 2'd0);
        vecs[1]  = mk(0, 2'd1, 8'd128, 0, 8'h00, 1, 2'd1);
        vecs[2]  = mk(0, 2'd1, 8'd1,   0, 8'h01, 0, 2'd1);
        vecs[3]  = mk(0, 2'd1, 8'd1,   0, 8'h02, 0, 2'd1);
        vecs[4]  = mk(0, 2'd1, 8'd1,   0, 8'h03, 0, 2'd1);
        vecs[5]  = mk(1, 2'd0, 8'd64,  0, 8'hFF, 0, 2'd0);
        vecs[6]  = mk(0, 2'd0, 8'd64,  0, 8'h00, 0, 2'd0);
        vecs[7]  = mk(0, 2'd0, 8'd64,  0, 8'h00, 0, 2'd0);
        vecs[8]  = mk(0, 2'd0, 8'd64,  0, 8'hFF, 1, 2'd0);
        vecs[9]  = mk(0, 2'd1, 8'd192, 0, 8'h00, 0, 2'd0);
        vecs[10] = mk(0, 2'd1, 8'd64,  0, 8'h00, 1, 2'd1);
        vecs[11] = mk(0, 2'd1, 8'd64,  0, 8'h40, 0, 2'd1);
        vecs[12] = mk(0, 2'd0, 8'd64,  0, 8'h80, 0, 2'd1);
        vecs[13] = mk(0, 2'd0, 8'd64,  0, 8'hC0, 0, 2'd1);
        vecs[14] = mk(0, 2'd0, 8'd64,  0, 8'hFF, 1, 2'd0);
        vecs[15] = mk(0, 2'd2, 8'd64,  0, 8'hFF, 0, 2'd0);
        vecs[16] = mk(0, 2'd2, 8'd192, 0, 8'h00, 1, 2'd2);
        vecs[17] = mk(0, 2'd2, 8'd32,  0, 8'h40, 0, 2'd2);
        vecs[18] = mk(0, 2'd2, 8'd96,  0, 8'hFF, 0, 2'd2);
        vecs[19] = mk(0, 2'd2, 8'd64,  0, 8'h7F, 0, 2'd2);
        vecs[20] = mk(0, 2'd2, 8'd64,  1, 8'h00, 0, 2'd2);
        vecs[21] = mk(0, 2'd2, 8'd0,   0, 8'h7F, 0, 2'd2);
`ifdef WAVE_SINE_EN
        vecs[22] = mk(0, 2'd3, 8'd64,  0, 8'h82, 1, 2'd3);
        vecs[23] = mk(0, 2'd3, 8'd64,  0, 8'hFF, 0, 2'd3);
        vecs[24] = mk(0, 2'd3, 8'd64,  0, 8'h7D, 0, 2'd3);
        vecs[25] = mk(0, 2'd3, 8'd64,  0, 8'h00, 0, 2'd3);
`else
        vecs[22] = mk(0, 2'd3, 8'd64,  0, 8'h80, 1, 2'd3);
        vecs[23] = mk(0, 2'd3, 8'd64,  0, 8'h80, 0, 2'd3);
        vecs[24] = mk(0, 2'd3, 8'd64,  0, 8'h80, 0, 2'd3);
        vecs[25] = mk(0, 2'd3, 8'd64,  0, 8'h80, 0, 2'd3);
`endif

        do_reset();
        @(negedge clock_in);
        check("reset_sample", sample, 8'h00);
        check("reset_valid", {7'd0, sample_valid}, 8'd0);
        check("reset_wrap", {7'd0, wrap}, 8'd0);
        check("reset_active", {6'd0, wave_active}, 8'd0);

        for (int i = 0; i < NumVec; i++) apply(vecs[i], i);

        // Latency: step first sampled at posedge N, valid only at N+3.
        do_reset();
        @(negedge clock_in);
        wave_sel  = 2'd0;
        phase_inc = 8'd16;
        e.sample = 8'hFF; e.wrap = 1'b0; e.act = 2'd0;
        sb.push_back(e);
        step_in = 1'b1;
        @(posedge clock_in);
        #1 check("latency_n0", {7'd0, sample_valid}, 8'd0);
        @(posedge clock_in);
        #1 check("latency_n1", {7'd0, sample_valid}, 8'd0);
        @(posedge clock_in);
        #1 check("latency_n2", {7'd0, sample_valid}, 8'd0);
        @(posedge clock_in);
        #1 check("latency_n3", {7'd0, sample_valid}, 8'd1);
        @(negedge clock_in);
        step_in = 1'b0;
        repeat (4) @(negedge clock_in);
        check("latency_sb_empty", 8'(sb.size()), 8'd0);

        // Reset lands at N+2 of an in-flight edge; step_in stays high afterwards.
        @(negedge clock_in);
        step_in = 1'b1;
        base    = n_valid;
        @(posedge clock_in);
        @(posedge clock_in);
        #1 reset_n = 1'b0;
        @(posedge clock_in);
        @(negedge clock_in);
        @(negedge clock_in);
        reset_n = 1'b1;
        repeat (8) @(negedge clock_in);
        check("midreset_no_valid", 8'(n_valid - base), 8'd0);
        check("midreset_sample", sample, 8'h00);
        check("midreset_active", {6'd0, wave_active}, 8'd0);
        step_in = 1'b0;
        repeat (4) @(negedge clock_in);
        check("midreset_sb_empty", 8'(sb.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
